// File: rtl/sys_cmd_ctrl.sv
// Command decoder/sequencer: turns UART RX byte frames into register-file strobes and returns read data on a TX handshake.
// Optional inter-byte timeout is compiled in with `define CMD_TIMEOUT_EN.
module sys_cmd_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_WR     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] CMD_RD     = 8'hBB
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int                    TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_VLD,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    input  logic                  TX_RDY,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VLD,
    output logic                  CMD_ERR
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic                  r_wrEn, w_wrEn;
    logic                  r_rdEn, w_rdEn;
    logic                  r_cmdErr, w_cmdErr;
    logic                  r_txVld, w_txVld;
    logic [ADDR_WIDTH-1:0] r_address, w_address;
    logic [DATA_WIDTH-1:0] r_wrData, w_wrData;
    logic [DATA_WIDTH-1:0] r_txData, w_txData;
    logic                  w_addrOk;

    assign w_addrOk = (RX_DATA[DATA_WIDTH-1:ADDR_WIDTH] == '0);

`ifdef CMD_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] r_tmo, w_tmoNext;
    logic        w_timed;

    assign w_timed = (r_state == WR_ADDR) || (r_state == WR_DATA) ||
                     (r_state == RD_ADDR) || (r_state == RD_WAIT);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_wrEn    <= 1'b0;
            r_rdEn    <= 1'b0;
            r_cmdErr  <= 1'b0;
            r_txVld   <= 1'b0;
            r_address <= '0;
            r_wrData  <= '0;
            r_txData  <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_wrEn    <= w_wrEn;
            r_rdEn    <= w_rdEn;
            r_cmdErr  <= w_cmdErr;
            r_txVld   <= w_txVld;
            r_address <= w_address;
            r_wrData  <= w_wrData;
            r_txData  <= w_txData;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= w_tmoNext;
        end
    end
`endif

    // All strobes are computed one cycle ahead and registered, so they appear the cycle after the byte.
    always_comb begin
        w_stateNext = r_state;
        w_wrEn      = 1'b0;
        w_rdEn      = 1'b0;
        w_cmdErr    = 1'b0;
        w_txVld     = r_txVld;
        w_address   = r_address;
        w_wrData    = r_wrData;
        w_txData    = r_txData;
`ifdef CMD_TIMEOUT_EN
        w_tmoNext   = '0;
`endif
        case (r_state)
            IDLE: begin
                if (RX_VLD) begin
                    if (RX_DATA == CMD_WR) begin
                        w_stateNext = WR_ADDR;
                    end else if (RX_DATA == CMD_RD) begin
                        w_stateNext = RD_ADDR;
                    end else begin
                        w_cmdErr = 1'b1;
                    end
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (RX_VLD) begin
                    if (!w_addrOk) begin
                        w_cmdErr    = 1'b1;
                        w_stateNext = IDLE;
                    end else begin
                        w_address = RX_DATA[ADDR_WIDTH-1:0];
                        if (r_state == WR_ADDR) begin
                            w_stateNext = WR_DATA;
                        end else begin
                            w_rdEn      = 1'b1;
                            w_stateNext = RD_WAIT;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (RX_VLD) begin
                    w_wrData    = RX_DATA;
                    w_wrEn      = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            RD_WAIT: begin
                w_cmdErr = RX_VLD;
                if (RdData_Valid) begin
                    w_txData    = RdData;
                    w_txVld     = 1'b1;
                    w_stateNext = TX_SEND;
                end
            end
            TX_SEND: begin
                w_cmdErr = RX_VLD;
                if (TX_RDY) begin
                    w_txVld     = 1'b0;
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
`ifdef CMD_TIMEOUT_EN
        // Counter restarts on any byte or state change; hitting the limit abandons the frame.
        if (w_timed && !RX_VLD && (w_stateNext == r_state)) begin
            if (r_tmo == TMO_LIMIT) begin
                w_cmdErr    = 1'b1;
                w_stateNext = IDLE;
            end else begin
                w_tmoNext = r_tmo + 16'd1;
            end
        end
`endif
    end

    assign WrEn    = r_wrEn;
    assign RdEn    = r_rdEn;
    assign CMD_ERR = r_cmdErr;
    assign TX_VLD  = r_txVld;
    assign Address = r_address;
    assign WrData  = r_wrData;
    assign TX_DATA = r_txData;

endmodule

// File: doc/sys_cmd_ctrl.md
Name: sys_cmd_ctrl

Overview:
- Command decoder and sequencer between the UART RX byte stream and the register file.
- Parses byte frames into single-cycle write and read strobes (WrEn/RdEn/Address/WrData).
- Captures RdData on RdData_Valid and returns it as a response byte on a valid/ready TX interface toward the UART TX path.
- Guarantees WrEn and RdEn are never asserted in the same cycle.

Parameters:
- DATA_WIDTH, 8, width of RX bytes, WrData, RdData and TX_DATA.
- ADDR_WIDTH, 4, register address width; register count is 2**ADDR_WIDTH.
- CMD_WR, 8'hAA, opcode for a write frame: opcode, address, data.
- CMD_RD, 8'hBB, opcode for a read frame: opcode, address.
- TIMEOUT_CYCLES, 255, inter-byte timeout; used only when CMD_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- RX_DATA  input  DATA_WIDTH  received byte, valid when RX_VLD=1.
- RX_VLD  input  1  one-cycle pulse per received byte.
- RdData  input  DATA_WIDTH  read data from the register file.
- RdData_Valid  input  1  one-cycle pulse qualifying RdData.
- TX_RDY  input  1  downstream accepts TX_DATA when TX_RDY=1 and TX_VLD=1.
- WrEn  output  1  one-cycle write strobe.
- RdEn  output  1  one-cycle read strobe.
- Address  output  ADDR_WIDTH  register address, held from the address byte until the next frame.
- WrData  output  DATA_WIDTH  write data, valid with WrEn.
- TX_DATA  output  DATA_WIDTH  response byte.
- TX_VLD  output  1  response valid, held until accepted.
- CMD_ERR  output  1  one-cycle pulse on any frame or protocol error.

Behaviour:
- Reset, asynchronous and active-high, forces state IDLE and all outputs to 0: WrEn, RdEn, Address, WrData, TX_DATA, TX_VLD, CMD_ERR. Internal capture registers also clear to 0.
- Reset asserted mid-frame discards the partial frame.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE, on RX_VLD:
  - RX_DATA==CMD_WR -> WR_ADDR.
  - RX_DATA==CMD_RD -> RD_ADDR.
  - Any other byte -> CMD_ERR pulse next cycle; stay IDLE.
- WR_ADDR / RD_ADDR, on RX_VLD:
  - If RX_DATA[DATA_WIDTH-1:ADDR_WIDTH] != 0 -> CMD_ERR pulse; go IDLE; no strobe.
  - Otherwise latch Address = RX_DATA[ADDR_WIDTH-1:0].
  - WR_ADDR -> WR_DATA.
  - RD_ADDR -> assert RdEn for exactly 1 cycle (the cycle after the byte) -> RD_WAIT.
- WR_DATA, on RX_VLD:
  - Latch WrData = RX_DATA.
  - Assert WrEn for exactly 1 cycle (the cycle after the byte) -> IDLE.
  - Latency from data-byte RX_VLD to WrEn: 1 cycle.
- RD_WAIT, on RdData_Valid: TX_DATA <= RdData, TX_VLD <= 1 -> TX_SEND.
  - Register file returns data one cycle after RdEn, so TX_VLD rises 2 cycles after RdEn.
- TX_SEND:
  - TX_VLD and TX_DATA are held stable until the cycle where TX_RDY=1.
  - On that cycle TX_VLD drops to 0 next cycle -> IDLE.
- RX_VLD in RD_WAIT or TX_SEND: byte dropped, CMD_ERR pulse, state and TX_DATA unchanged.
- RdData_Valid in any state other than RD_WAIT is ignored.
- A new opcode can be accepted in the cycle immediately after the return to IDLE.
- Back-to-back RX_VLD pulses on consecutive cycles are supported.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter runs in WR_ADDR, WR_DATA, RD_ADDR and RD_WAIT.
  - The counter clears on every RX_VLD and on each state entry.
  - When it reaches TIMEOUT_CYCLES: CMD_ERR pulse, go IDLE, no strobe issued.
  - TX_SEND never times out.
- Undefined: no counter; partial frames and RD_WAIT wait indefinitely. TIMEOUT_CYCLES is unused.

Test Plan:
- Write frame: reset, RX bytes AA,05,3C -> WrEn=1 for 1 cycle with Address=5, WrData=0x3C; RdEn stays 0; CMD_ERR stays 0.
- Read frame: RX BB,02 with RdData=0x81 pulsed 1 cycle after RdEn -> RdEn 1 cycle with Address=2; TX_VLD=1, TX_DATA=0x81. Hold TX_RDY=0 for 5 cycles -> TX_VLD stays 1 and TX_DATA stable. Then TX_RDY=1 -> TX_VLD=0 next cycle.
- Bad input: RX 0x12 in IDLE -> CMD_ERR pulse, no strobes. Then RX AA,15 -> CMD_ERR (0x15 out of range for ADDR_WIDTH=4), return IDLE, no WrEn.
- Overrun: during TX_SEND with TX_RDY=0, RX 0xAA -> CMD_ERR pulse, TX_DATA unchanged; after TX_RDY, a fresh AA,01,FF frame writes 0xFF to address 1.
- Reset mid-frame: RX AA,07, then RST high 2 cycles -> all outputs 0. Next RX 0x55 -> CMD_ERR, proving the state is IDLE and not WR_DATA.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=10: RX BB only -> CMD_ERR pulse after 10 idle cycles, no RdEn. Without the macro -> no CMD_ERR, and a later 03 completes the read of address 3.
